// File: rtl/game2048_pkg.sv
// Shared types and constants for the 2048 line processing blocks.
package game2048_pkg;

  localparam int unsigned TILE_W           = 4;
  localparam int unsigned EMPTY_CODE       = 0;
  localparam int unsigned DEFAULT_WIN_CODE = 11;

  typedef logic [TILE_W-1:0] tile_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/line_merge_step.sv
// One scan step of the slide/merge: folds element e into the pending tile.
module line_merge_step
  import game2048_pkg::*;
#(
  parameter int unsigned VAL_W   = TILE_W,
  parameter int unsigned SCORE_W = 16
) (
  input  logic [VAL_W-1:0]   pend,
  input  logic               pend_v,
  input  logic [VAL_W-1:0]   e,
  output logic               write_en,
  output logic [VAL_W-1:0]   write_val,
  output logic [VAL_W-1:0]   pend_nxt,
  output logic               pend_v_nxt,
  output logic [SCORE_W-1:0] score_inc
);

  localparam logic [VAL_W-1:0] MAX_CODE = '1;

  logic [VAL_W-1:0] merged;

  always_comb begin
    merged     = e + VAL_W'(1);
    write_en   = 1'b0;
    write_val  = pend;
    pend_nxt   = pend;
    pend_v_nxt = pend_v;
    score_inc  = '0;
    if (e != VAL_W'(EMPTY_CODE)) begin
      if (pend_v && (pend == e) && (e != MAX_CODE)) begin
        write_en   = 1'b1;
        write_val  = merged;
        pend_v_nxt = 1'b0;
        // Tile values too large for the score field saturate the increment.
        if (32'(merged) >= SCORE_W) score_inc = '1;
        else                        score_inc = SCORE_W'(1) << merged;
      end else if (pend_v) begin
        write_en  = 1'b1;
        write_val = pend;
        pend_nxt  = e;
      end else begin
        pend_nxt   = e;
        pend_v_nxt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/line_merge_engine.sv
// Sequential 2048 line slide/merge engine, one element per cycle.
// Optional LINE_MERGE_DIR_EN adds a dir input that slides toward index LEN-1.
module line_merge_engine
  import game2048_pkg::*;
#(
  parameter int unsigned LEN      = 4,
  parameter int unsigned VAL_W    = 4,
  parameter int unsigned SCORE_W  = 16,
  parameter int unsigned WIN_CODE = DEFAULT_WIN_CODE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LEN*VAL_W-1:0] line_in,
`ifdef LINE_MERGE_DIR_EN
  input  logic                 dir,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LEN*VAL_W-1:0] line_out,
  output logic [SCORE_W-1:0]   score_delta,
  output logic                 moved,
  output logic                 win
);

  localparam int unsigned IDX_W = $clog2(LEN);
  localparam int unsigned LINE_W = LEN * VAL_W;

  state_e             state, state_nxt;
  logic [LINE_W-1:0]  line_q, buf_nxt;
  logic [IDX_W-1:0]   rd, wr, rd_pos, wr_pos;
  logic [VAL_W-1:0]   pend, e;
  logic               pend_v, accept, dir_sel;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_nxt;
  logic               moved_nxt, win_nxt;

  logic               st_write_en, st_pend_v_nxt;
  logic [VAL_W-1:0]   st_write_val, st_pend_nxt;
  logic [SCORE_W-1:0] st_score_inc;

`ifdef LINE_MERGE_DIR_EN
  logic dir_q;
  assign dir_sel = dir_q;
`else
  assign dir_sel = 1'b0;
`endif

  assign accept = in_valid && in_ready;

  line_merge_step #(.VAL_W(VAL_W), .SCORE_W(SCORE_W)) u_step (
    .pend       (pend),
    .pend_v     (pend_v),
    .e          (e),
    .write_en   (st_write_en),
    .write_val  (st_write_val),
    .pend_nxt   (st_pend_nxt),
    .pend_v_nxt (st_pend_v_nxt),
    .score_inc  (st_score_inc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = SCAN;
      SCAN:    if (rd == IDX_W'(LEN-1)) state_nxt = FLUSH;
      FLUSH:   state_nxt = DONE;
      DONE:    if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath next values: element fetch, buffer write, saturating score, flags.
  always_comb begin
    rd_pos    = dir_sel ? (IDX_W'(LEN-1) - rd) : rd;
    wr_pos    = dir_sel ? (IDX_W'(LEN-1) - wr) : wr;
    e         = line_q[rd_pos*VAL_W +: VAL_W];
    buf_nxt   = line_out;
    score_sum = {1'b0, score_delta} + {1'b0, st_score_inc};
    score_nxt = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    if (state == SCAN && st_write_en) buf_nxt[wr_pos*VAL_W +: VAL_W] = st_write_val;
    if (state == FLUSH && pend_v)     buf_nxt[wr_pos*VAL_W +: VAL_W] = pend;
    moved_nxt = (buf_nxt != line_q);
    win_nxt   = 1'b0;
    for (int i = 0; i < int'(LEN); i++) begin
      if (buf_nxt[i*VAL_W +: VAL_W] == VAL_W'(WIN_CODE)) win_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      line_q      <= '0;
      line_out    <= '0;
      score_delta <= '0;
      moved       <= 1'b0;
      win         <= 1'b0;
      rd          <= '0;
      wr          <= '0;
      pend        <= '0;
      pend_v      <= 1'b0;
`ifdef LINE_MERGE_DIR_EN
      dir_q       <= 1'b0;
`endif
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state == DONE) && !(out_valid && out_ready);
      case (state)
        IDLE: if (accept) begin
          line_q      <= line_in;
          line_out    <= '0;
          score_delta <= '0;
          moved       <= 1'b0;
          win         <= 1'b0;
          rd          <= '0;
          wr          <= '0;
          pend        <= '0;
          pend_v      <= 1'b0;
`ifdef LINE_MERGE_DIR_EN
          dir_q       <= dir;
`endif
        end
        SCAN: begin
          line_out    <= buf_nxt;
          score_delta <= score_nxt;
          pend        <= st_pend_nxt;
          pend_v      <= st_pend_v_nxt;
          rd          <= rd + IDX_W'(1);
          if (st_write_en) wr <= wr + IDX_W'(1);
        end
        FLUSH: begin
          line_out <= buf_nxt;
          moved    <= moved_nxt;
          win      <= win_nxt;
          pend_v   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_merge_engine.sv
// Directed self-checking bench for line_merge_engine (default build, LEN=4).
module tb_line_merge_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] line_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] line_out;
  logic [15:0] score_delta;
  logic        moved;
  logic        win;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  line_merge_engine dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .line_in     (line_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .line_out    (line_out),
    .score_delta (score_delta),
    .moved       (moved),
    .win         (win)
  );

  function automatic logic [15:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {4'(a3), 4'(a2), 4'(a1), 4'(a0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accepts one line, measures latency to out_valid, checks results.
  task automatic send_line(input string tag, input logic [15:0] l, output int lat);
    @(negedge clk);
    line_in  = l;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd6);
  endtask

  task automatic run_line(input string tag, input logic [15:0] l, input logic [15:0] exp_line,
                          input logic [15:0] exp_score, input logic exp_moved, input logic exp_win);
    int lat;
    send_line(tag, l, lat);
    check({tag, "_line"},  32'(line_out),    32'(exp_line));
    check({tag, "_score"}, 32'(score_delta), 32'(exp_score));
    check({tag, "_moved"}, 32'(moved),       32'(exp_moved));
    check({tag, "_win"},   32'(win),         32'(exp_win));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    line_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),    32'd1);
    check("rst_out_valid", 32'(out_valid),   32'd0);
    check("rst_line_out",  32'(line_out),    32'd0);
    check("rst_score",     32'(score_delta), 32'd0);
    check("rst_moved",     32'(moved),       32'd0);
    check("rst_win",       32'(win),         32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_line("l1120", pk(1,1,2,0),   pk(2,2,0,0),   16'd4,    1'b1, 1'b0);
    run_line("l1111", pk(1,1,1,1),   pk(2,2,0,0),   16'd8,    1'b1, 1'b0);
    run_line("l2424", pk(2,4,2,4),   pk(2,4,2,4),   16'd0,    1'b0, 1'b0);
    run_line("l0003", pk(0,0,0,3),   pk(3,0,0,0),   16'd0,    1'b1, 1'b0);
    run_line("lmax",  pk(15,15,0,0), pk(15,15,0,0), 16'd0,    1'b0, 1'b0);
    run_line("lwin",  pk(10,10,0,0), pk(11,0,0,0),  16'd2048, 1'b1, 1'b1);

    // Backpressure in DONE: outputs hold while in_valid/line_in wiggle.
    send_line("hold", pk(1,1,2,0), lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = k[0];
      line_in  = 16'(16'h1234 * (k + 1));
      @(posedge clk);
      #1;
      check("hold_valid", 32'(out_valid),   32'd1);
      check("hold_ready", 32'(in_ready),    32'd0);
      check("hold_line",  32'(line_out),    32'(pk(2,2,0,0)));
      check("hold_score", 32'(score_delta), 32'd4);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("rel_valid", 32'(out_valid), 32'd0);
    check("rel_ready", 32'(in_ready),  32'd1);

    // Reset during the second SCAN cycle aborts the line.
    @(negedge clk);
    line_in  = pk(3,3,3,3);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("scan_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_valid", 32'(out_valid),   32'd0);
    check("abort_line",  32'(line_out),    32'd0);
    check("abort_ready", 32'(in_ready),    32'd1);
    check("abort_score", 32'(score_delta), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_valid", 32'(out_valid), 32'd0);

    run_line("l1100", pk(1,1,0,0), pk(2,0,0,0), 16'd4, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
